// File: rtl/map_ram.sv
// Dual-port map memory with post-reset clear sweep and a multi-channel reference bank.
// Optional macro RAM_BYPASS_EN selects write-first on same-address read/write (default read-first).
module map_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int REF_W  = 16,
  parameter int REF_CH = 2,
  localparam int SEL_W = (REF_CH > 1) ? $clog2(REF_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  input  logic                    ref_we,
  input  logic [SEL_W-1:0]        ref_sel,
  output logic [REF_CH*REF_W-1:0] ref_out,
  output logic                    init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] sweep;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              collide;

  assign run       = (state == RUN);
  assign init_busy = (state == CLEAR);
  assign collide   = wr_en && (wr_addr == rd_addr);

  // Single write port shared between the clear sweep and normal writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!rst) begin
      if (!run) begin
        mem_we    = 1'b1;
        mem_waddr = sweep;
        mem_wdata = '0;
      end else if (wr_en) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Sequencer: CLEAR sweeps every address once, then hands over to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      sweep <= '0;
    end else if (!run) begin
      sweep <= sweep + 1'b1;
      if (sweep == {ADDR_W{1'b1}}) begin
        state <= RUN;
      end
    end
  end

  // Read port: one-cycle latency, data held when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= run && rd_en;
      if (run && rd_en) begin
`ifdef RAM_BYPASS_EN
        rd_data <= collide ? wr_data : mem[rd_addr];
`else
        rd_data <= mem[rd_addr];
`endif
      end
    end
  end

  // Out-of-range selects match no channel and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_out <= '0;
    end else if (run && ref_we) begin
      for (int k = 0; k < REF_CH; k++) begin
        if (int'(ref_sel) == k) begin
          ref_out[k*REF_W +: REF_W] <= wr_data[REF_W-1:0];
        end
      end
    end
  end

`ifndef RAM_BYPASS_EN
  logic unused_collide;
  assign unused_collide = collide;
`endif

endmodule

// File: tb/tb_map_ram.sv
// Self-checking bench for map_ram: directed test-plan steps plus randomized traffic vs. an array model.
module tb_map_ram;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int REF_W  = 16;
  localparam int REF_CH = 3;
  localparam int SEL_W  = 2;
  localparam int DEPTH  = 256;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_valid;
  logic                    ref_we;
  logic [SEL_W-1:0]        ref_sel;
  logic [REF_CH*REF_W-1:0] ref_out;
  logic                    init_busy;

  map_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REF_W(REF_W), .REF_CH(REF_CH)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .ref_we(ref_we), .ref_sel(ref_sel), .ref_out(ref_out),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [REF_W-1:0]  ref_m [REF_CH];
  logic [DATA_W-1:0] exp_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [REF_CH*REF_W-1:0] ref_exp();
    logic [REF_CH*REF_W-1:0] v;
    for (int k = 0; k < REF_CH; k++) v[k*REF_W +: REF_W] = ref_m[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    for (int k = 0; k < REF_CH; k++) ref_m[k] = '0;
    exp_rd = '0;
  endtask

  task automatic idle();
    wr_en = 0; rd_en = 0; ref_we = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; ref_sel = '0;
  endtask

  // One RUN-mode cycle: predict from current inputs, clock, compare all outputs.
  task automatic run_cycle(input string tag);
    logic [DATA_W-1:0] nd;
    logic nv;
    nd = exp_rd;
    nv = 1'b0;
    if (rd_en) begin
      nv = 1'b1;
      nd = mem_m[rd_addr];
`ifdef RAM_BYPASS_EN
      if (wr_en && wr_addr == rd_addr) nd = wr_data;
`endif
    end
    if (wr_en) mem_m[wr_addr] = wr_data;
    if (ref_we && int'(ref_sel) < REF_CH) ref_m[ref_sel] = wr_data[REF_W-1:0];
    step();
    exp_rd = nd;
    check({tag, ".rd_valid"}, 64'(rd_valid), 64'(nv));
    check({tag, ".rd_data"}, 64'(rd_data), 64'(nd));
    check({tag, ".ref_out"}, 64'(ref_out), 64'(ref_exp()));
    check({tag, ".busy"}, 64'(init_busy), 64'd0);
  endtask

  task automatic do_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] want);
    idle();
    rd_en = 1; rd_addr = a;
    run_cycle(tag);
    check({tag, ".value"}, 64'(rd_data), 64'(want));
    idle();
    run_cycle({tag, ".after"});
  endtask

  initial begin
    int n;
    logic [DATA_W-1:0] old_val;
    idle();
    model_reset();

    // Reset for two cycles
    rst = 1;
    step(); step();
    check("rst.rd_data", 64'(rd_data), 64'd0);
    check("rst.rd_valid", 64'(rd_valid), 64'd0);
    check("rst.ref_out", 64'(ref_out), 64'd0);
    check("rst.busy", 64'(init_busy), 64'd1);
    rst = 0;

    n = 0;
    while (init_busy && n < 1000) begin
      check("clear.rd_valid", 64'(rd_valid), 64'd0);
      step();
      n++;
    end
    check("clear.length", 64'(n), 64'(DEPTH));

    do_read("clr0", 8'h00, 32'h0);
    do_read("clr128", 8'h80, 32'h0);
    do_read("clr255", 8'hFF, 32'h0);

    // Read after write
    idle(); wr_en = 1; wr_addr = 8'h10; wr_data = 32'hDEADBEEF;
    run_cycle("raw.wr");
    do_read("raw.rd", 8'h10, 32'hDEADBEEF);

    // Same-address collision
    idle(); wr_en = 1; wr_addr = 8'h20; wr_data = 32'h11111111;
    run_cycle("col.pre");
    idle(); wr_en = 1; wr_addr = 8'h20; wr_data = 32'h22222222; rd_en = 1; rd_addr = 8'h20;
    run_cycle("col.same");
`ifdef RAM_BYPASS_EN
    check("col.value", 64'(rd_data), 64'h22222222);
`else
    check("col.value", 64'(rd_data), 64'h11111111);
`endif
    do_read("col.reread", 8'h20, 32'h22222222);

    // Reference bank
    idle(); ref_we = 1; ref_sel = 2'd1; wr_data = 32'h0000ABCD;
    run_cycle("ref.ld1");
    check("ref.ld1.value", 64'(ref_out), 64'h0000_ABCD_0000);
    idle(); ref_we = 1; ref_sel = 2'd3; wr_data = 32'h00001234;
    run_cycle("ref.oor");
    check("ref.oor.value", 64'(ref_out), 64'h0000_ABCD_0000);
    idle(); ref_we = 1; ref_sel = 2'd2; wr_en = 1; wr_addr = 8'h30; wr_data = 32'h5A5A9876;
    run_cycle("ref.both");
    check("ref.both.value", 64'(ref_out), 64'h9876_ABCD_0000);
    do_read("ref.both.mem", 8'h30, 32'h5A5A9876);

    // Randomized traffic on a narrow address window to provoke collisions
    for (int i = 0; i < 400; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      ref_we  = ($urandom_range(0, 3) == 0);
      wr_addr = 8'($urandom_range(0, 15));
      rd_addr = 8'($urandom_range(0, 15));
      wr_data = $urandom;
      ref_sel = 2'($urandom_range(0, 3));
      run_cycle("rand");
    end

    // Reset mid-operation
    idle(); wr_en = 1; wr_addr = 8'h01; wr_data = 32'h12345678; ref_we = 1; ref_sel = 2'd0;
    run_cycle("mid.wr");
    idle(); rd_en = 1; rd_addr = 8'h01;
    run_cycle("mid.rd");
    check("mid.rd.value", 64'(rd_data), 64'h12345678);
    idle();
    rst = 1;
    step();
    model_reset();
    check("mid.rst.rd_data", 64'(rd_data), 64'd0);
    check("mid.rst.rd_valid", 64'(rd_valid), 64'd0);
    check("mid.rst.ref_out", 64'(ref_out), 64'd0);
    check("mid.rst.busy", 64'(init_busy), 64'd1);
    rst = 0;

    // Accesses during the sweep are dropped
    n = 0;
    while (init_busy && n < 1000) begin
      if (n == 10) begin
        wr_en = 1; wr_addr = 8'h05; wr_data = 32'h00000055;
        rd_en = 1; rd_addr = 8'h05; ref_we = 1; ref_sel = 2'd0;
      end else begin
        idle();
      end
      step();
      n++;
      check("swp.rd_valid", 64'(rd_valid), 64'd0);
      check("swp.ref_out", 64'(ref_out), 64'd0);
    end
    idle();
    check("swp.length", 64'(n), 64'(DEPTH));
    do_read("swp.rd05", 8'h05, 32'h0);
    do_read("swp.rd01", 8'h01, 32'h0);

    // Spot-check that the earlier random window was wiped
    for (int a = 0; a < 16; a++) begin
      old_val = mem_m[a];
      do_read("swp.win", 8'(a), old_val);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/map_ram.md
# map_ram

Parametrised dual-port map memory with built-in clear sequencer and a multi-channel reference register bank. It replaces the fixed 256x32 map RAM used by the vacuum navigation path. It adds:
- simultaneous read and write in one cycle;
- a read-valid strobe;
- automatic zeroing of the whole array after reset;
- REF_CH independently loadable reference words instead of a single one.

## Interface
Parameters:
- DATA_W, 32, width of each memory word and of the write/read data buses
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
- REF_W, 16, width of each reference channel (REF_W <= DATA_W)
- REF_CH, 2, number of reference channels (>= 1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data; also the source for reference loads
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle strobe; rd_data is valid in this cycle
- ref_we  in  1  reference load strobe
- ref_sel  in  max(1,$clog2(REF_CH))  reference channel select
- ref_out  out  REF_CH*REF_W  all reference channels; channel k occupies bits [k*REF_W +: REF_W]
- init_busy  out  1  high while the clear sweep runs; ports are ignored while high

## Operation
- FSM states:
  - CLEAR: entered on rst. A sweep counter runs 0..DEPTH-1 and writes zero to each address, one per cycle. After writing DEPTH-1, go to RUN.
  - RUN: normal access.
- Reset values: rd_data = 0, rd_valid = 0, ref_out = 0, init_busy = 1, sweep counter = 0, state = CLEAR.
- In CLEAR:
  - wr_en, rd_en and ref_we are dropped, not queued.
  - rd_valid stays 0.
- In RUN:
  - wr_en=1: Mem[wr_addr] <= wr_data.
  - rd_en=1: rd_data <= Mem[rd_addr] and rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its last value.
  - A read and a write in the same cycle are both performed. If the addresses differ, there is no interaction.
  - A same-address collision is resolved per Configuration.
- Reference bank:
  - In RUN, ref_we=1 loads wr_data[REF_W-1:0] into channel ref_sel.
  - ref_sel >= REF_CH: the load is ignored and no channel changes.
  - ref_we is independent of wr_en. Both may be high in one cycle; memory and reference are then both updated from the same wr_data.
- rst asserted mid-sweep or mid-RUN: the sweep restarts from address 0 and all outputs return to their reset values. Memory contents are not preserved.

## Timing
- Clear sweep lasts exactly DEPTH cycles, 256 at defaults.
  - init_busy is high from the first cycle after rst deasserts through the DEPTH-th cycle.
  - init_busy falls together with the CLEAR->RUN transition.
  - The first port access is accepted on the edge where init_busy is already 0.
- Read latency is 1 cycle: rd_en sampled at edge N gives rd_data/rd_valid valid after edge N, for one cycle.
- Back-to-back reads are accepted every cycle, so rd_valid can stay high continuously.
- A write is visible to a read issued on the following cycle.
- Reference load: ref_out updates at the edge sampling ref_we.

## Configuration
- RAM_BYPASS_EN defined: write-first. On a same-cycle read/write to the same address, rd_data returns wr_data.
- RAM_BYPASS_EN undefined: read-first. rd_data returns the pre-write memory contents; the new value is readable from the next cycle.
- Either way, the memory holds wr_data after the edge.

## Test plan
- Clear and first read: rst for 2 cycles, release; wait for init_busy to fall; read addresses 0, 128, 255 -> init_busy high for exactly 256 cycles, and each read returns 0x00000000 with rd_valid high 1 cycle after rd_en.
- Read after write: write 0xDEADBEEF to address 0x10, then read 0x10 next cycle -> rd_data = 0xDEADBEEF, rd_valid single-cycle.
- Same-address collision: with 0x11111111 stored at 0x20, write 0x22222222 to 0x20 and read 0x20 in the same cycle:
  - without RAM_BYPASS_EN -> 0x11111111
  - with RAM_BYPASS_EN -> 0x22222222
  - either way, a re-read the next cycle -> 0x22222222
- Reference bank: wr_data=0x0000ABCD, ref_we=1, ref_sel=1 -> ref_out = 0xABCD_0000 (REF_CH=2). Then ref_sel=3 with REF_CH=3 -> ref_out unchanged.
- Accesses during clear: assert wr_en to 0x05 with 0x55, plus rd_en and ref_we, at sweep cycle 10 -> rd_valid stays 0, ref_out stays 0, and after the sweep address 0x05 reads 0.
- Reset mid-operation: write 0x12345678 to 0x01, then assert rst for 1 cycle -> rd_data and ref_out return to 0, init_busy rises, and after a full 256-cycle sweep address 0x01 reads 0.
